// File: rtl/imm_extend_pipe.sv
// Immediate-extension stage: sign/zero/upper/branch extension feeding a
// 2-entry valid/ready buffer between decode and execute.
//
// Ports:
//   clk, rst        clock, async active-high reset
//   flush           synchronous buffer clear (wins over push/pop)
//   inValid/inReady upstream handshake; inImm, inMode, inTag payload
//   outValid/outReady downstream handshake; outData, outTag = head entry
module imm_extend_pipe #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 32,
    parameter int BR_SHIFT  = 2,
    parameter int TAG_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 inValid,
    output logic                 inReady,
    input  logic [IN_WIDTH-1:0]  inImm,
    input  logic [1:0]           inMode,
    input  logic [TAG_WIDTH-1:0] inTag,
    output logic                 outValid,
    input  logic                 outReady,
    output logic [OUT_WIDTH-1:0] outData,
    output logic [TAG_WIDTH-1:0] outTag
);

    localparam int E = OUT_WIDTH - IN_WIDTH;

    localparam logic [1:0] MODE_SIGN   = 2'b00;
    localparam logic [1:0] MODE_ZERO   = 2'b01;
    localparam logic [1:0] MODE_UPPER  = 2'b10;

    logic [OUT_WIDTH-1:0] signExt;
    logic [OUT_WIDTH-1:0] extData;

    logic [1:0]           count;
    logic [OUT_WIDTH-1:0] headData;
    logic [TAG_WIDTH-1:0] headTag;
    logic [OUT_WIDTH-1:0] tailData;
    logic [TAG_WIDTH-1:0] tailTag;

    logic push;
    logic pop;

    always_comb begin
        signExt = {{E{inImm[IN_WIDTH-1]}}, inImm};
        extData = signExt;
        case (inMode)
            MODE_SIGN:  extData = signExt;
            MODE_ZERO:  extData = {{E{1'b0}}, inImm};
            MODE_UPPER: extData = {inImm, {E{1'b0}}};
            default:    extData = signExt << BR_SHIFT;
        endcase
    end

    // Ready comes only from registered occupancy, so execute-side
    // backpressure never forms a combinational path back to decode.
    assign inReady  = (count != 2'd2);
    assign outValid = (count != 2'd0);
    assign outData  = headData;
    assign outTag   = headTag;

    assign push = inValid & inReady;
    assign pop  = outValid & outReady;

    // The head slot always drives the outputs; the tail slot only holds
    // the second entry while the buffer is full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= 2'd0;
            headData <= '0;
            headTag  <= '0;
            tailData <= '0;
            tailTag  <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else if (push && !pop) begin
            if (count == 2'd0) begin
                headData <= extData;
                headTag  <= inTag;
            end else begin
                tailData <= extData;
                tailTag  <= inTag;
            end
            count <= count + 2'd1;
        end else if (pop && !push) begin
            // Empty-after-pop keeps the old head so outData holds its value.
            if (count == 2'd2) begin
                headData <= tailData;
                headTag  <= tailTag;
            end
            count <= count - 2'd1;
        end else if (push && pop) begin
            // Only reachable with one entry: the new word replaces the head.
            headData <= extData;
            headTag  <= inTag;
        end
    end

endmodule
